// File: rtl/reset_sequencer.sv
// Reset sequencer: turns one asynchronous active-high reset into ordered per-subsystem
// resets that assert at once and release synchronously, index 0 first.
module reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_OUTPUTS = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    output logic [NUM_OUTPUTS-1:0] rst_out,
    output logic                   seq_done
);

    localparam int MAX_CNT = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic [NUM_OUTPUTS-1:0]   rst_out_q, rst_out_d;
    logic                     seq_done_q, seq_done_d;
    logic [NUM_OUTPUTS-1:0]   rst_shift;
    logic                     hold_end;
    logic                     gap_end;

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
        // Shifting left clears the lowest still-asserted bit, so the order stays monotonic.
        rst_shift = rst_out_q << 1;
        hold_end  = (cnt_q == HOLD_LAST);
        gap_end   = (cnt_q == GAP_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // SYNC watches the value entering the last synchronizer flop so HOLD starts on the
    // same edge that flop goes high; release then lands on edge SYNC_STAGES+HOLD_CYCLES.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (sync_d[SYNC_STAGES-1]) state_d = HOLD;
            HOLD:    if (hold_end) state_d = (rst_shift == '0) ? DONE : RELEASE;
            RELEASE: if (gap_end && (rst_shift == '0)) state_d = DONE;
            DONE:    if (soft_rst_req) state_d = HOLD;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        rst_out_d  = rst_out_q;
        cnt_d      = '0;
        seq_done_d = (state_d == DONE);
        case (state_q)
            HOLD: begin
                if (hold_end) rst_out_d = rst_shift;
                else          cnt_d     = cnt_q + 1'b1;
            end
            RELEASE: begin
                if (gap_end) rst_out_d = rst_shift;
                else         cnt_d     = cnt_q + 1'b1;
            end
            DONE: begin
                if (soft_rst_req) rst_out_d = '1;
            end
            default: begin
                rst_out_d = rst_out_q;
            end
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            sync_q     <= '0;
            rst_out_q  <= '1;
            seq_done_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            rst_out_q  <= rst_out_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign seq_done = seq_done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a minimal-parameter instance.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soft_a = 1'b0;
    logic       soft_b = 1'b0;
    logic [2:0] rst_out_a;
    logic       done_a;
    logic [0:0] rst_out_b;
    logic       done_b;
    int         n_chk = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    reset_sequencer dut_a (
        .clk(clk), .rst(rst), .soft_rst_req(soft_a), .rst_out(rst_out_a), .seq_done(done_a)
    );

    reset_sequencer #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .NUM_OUTPUTS(1), .STAGE_GAP(1)) dut_b (
        .clk(clk), .rst(rst), .soft_rst_req(soft_b), .rst_out(rst_out_b), .seq_done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit k of the default instance is high before edge base+16+4k; done from base+24.
    function automatic logic [2:0] exp_vec(input int e, input int base);
        logic [2:0] v;
        for (int k = 0; k < 3; k++) v[k] = (e < base + 16 + 4 * k);
        return v;
    endfunction

    // Next posedge is edge 1 of the sequence being checked.
    task automatic run_seq(input string tag, input int base, input int last_e,
                           input bit chk_b, input bit ign_pulse);
        for (int e = 1; e <= last_e; e++) begin
            @(posedge clk);
            #1;
            chk({tag, "_out"}, {29'd0, rst_out_a}, {29'd0, exp_vec(e, base)});
            chk({tag, "_done"}, {31'd0, done_a}, {31'd0, e >= base + 24});
            if (chk_b) begin
                chk({tag, "_b_out"}, {31'd0, rst_out_b}, {31'd0, e < 4});
                chk({tag, "_b_done"}, {31'd0, done_b}, {31'd0, e >= 4});
            end
            if (ign_pulse) soft_a = (e == 11) || (e == 22);
        end
        soft_a = 1'b0;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_out_a", {29'd0, rst_out_a}, 32'h7);
        chk("rst_done_a", {31'd0, done_a}, 32'h0);
        chk("rst_out_b", {31'd0, rst_out_b}, 32'h1);
        chk("rst_done_b", {31'd0, done_b}, 32'h0);

        // Power-up with ignored soft requests at edges 12 (HOLD) and 23 (RELEASE).
        @(negedge clk);
        rst = 1'b0;
        run_seq("pwr", 2, 30, 1'b1, 1'b1);

        // Short async pulse between edges while in DONE.
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_out", {29'd0, rst_out_a}, 32'h7);
        chk("async_done", {31'd0, done_a}, 32'h0);
        chk("async_b_out", {31'd0, rst_out_b}, 32'h1);
        #2 rst = 1'b0;
        run_seq("re", 2, 28, 1'b1, 1'b0);

        // Restart in the middle of RELEASE.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_seq("mid_pre", 2, 20, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("mid_out", {29'd0, rst_out_a}, 32'h7);
        chk("mid_done", {31'd0, done_a}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_seq("mid", 2, 28, 1'b1, 1'b0);

        // Single-cycle soft reset sampled at edge S.
        @(negedge clk);
        soft_a = 1'b1;
        @(posedge clk);
        #1;
        soft_a = 1'b0;
        chk("soft_s_out", {29'd0, rst_out_a}, 32'h7);
        chk("soft_s_done", {31'd0, done_a}, 32'h0);
        chk("soft_b_stay", {31'd0, done_b}, 32'h1);
        run_seq("soft", 0, 28, 1'b0, 1'b0);

        // Held request: completes, pulses seq_done one cycle, then retriggers.
        @(negedge clk);
        soft_a = 1'b1;
        @(posedge clk);
        #1;
        chk("held_s_out", {29'd0, rst_out_a}, 32'h7);
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk);
            #1;
            if (e == 24) begin
                chk("held_done", {31'd0, done_a}, 32'h1);
                chk("held_out0", {29'd0, rst_out_a}, 32'h0);
            end
            if (e == 25) begin
                chk("held_retrig_out", {29'd0, rst_out_a}, 32'h7);
                chk("held_retrig_done", {31'd0, done_a}, 32'h0);
            end
        end
        soft_a = 1'b0;
        run_seq("held2", 0, 26, 1'b0, 1'b0);

        // Soft reset on the minimal instance: HOLD_CYCLES=1, single output.
        @(negedge clk);
        soft_b = 1'b1;
        @(posedge clk);
        #1;
        soft_b = 1'b0;
        chk("b_soft_out", {31'd0, rst_out_b}, 32'h1);
        chk("b_soft_done", {31'd0, done_b}, 32'h0);
        @(posedge clk);
        #1;
        chk("b_soft_rel", {31'd0, rst_out_b}, 32'h0);
        chk("b_soft_rel_done", {31'd0, done_b}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
